ahbl_splitter_burst: RTL and testbench
======================================

Name: ahbl_splitter_burst

Overview:
- Parametrised AHB-lite 1:N splitter with burst-aware decode, a built-in default slave, and error capture/counting.
- Sits below a master or arbiter and fans out to N slave ports.
- Burst beats (SEQ/BUSY) follow the port chosen by the burst's NONSEQ, so a burst never splits across ports.
- Unmapped, unconnected or overlapping addresses get a proper two-cycle ERROR response, and the offending address is captured.

Parameters:
- N_PORTS, 2, number of downstream slave ports.
- W_ADDR, 32, address width.
- W_DATA, 32, data width.
- W_MASTER, 8, HMASTER width.
- ADDR_MAP, {N_PORTS{W_ADDR'h0}}, per-port base address, port i at bits [i*W_ADDR +: W_ADDR].
- ADDR_MASK, {N_PORTS{W_ADDR'h0}}, per-port decode mask, same packing; port i hits when (haddr & MASK_i) == MAP_i.
- CONN_MASK, {N_PORTS{1'b1}}, bit i = 0 disconnects port i; a hit on it is a decode error.
- W_ERRCNT, 16, width of the saturating error counter.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- src_hready, input, 1, bus HREADY (tie to src_hready_resp at top level).
- src_hready_resp, output, 1, HREADYOUT to master.
- src_hresp, output, 1, HRESP to master.
- src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst, src_hprot, src_hmastlock, input, W_ADDR/1/2/3/3/4/1, address-phase controls.
- src_hexcl, input, 1, exclusive request.
- src_hmaster, input, W_MASTER, master ID.
- src_hwdata, input, W_DATA, write data.
- src_hrdata, output, W_DATA, read data.
- src_hexokay, output, 1, exclusive OK.
- dst_hready, output, N_PORTS, per-port HREADY.
- dst_hready_resp, dst_hresp, dst_hexokay, input, N_PORTS each, per-port responses.
- dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hexcl, dst_hmaster, dst_hwdata, output, packed N_PORTS×field width, per-port copies.
- dst_hrdata, input, N_PORTS*W_DATA, per-port read data.
- slave_sel_d, output, N_PORTS, one-hot data-phase select.
- err_count, output, W_ERRCNT, saturating count of decode errors.
- err_addr, output, W_ADDR, HADDR of the most recent decode error.
- err_valid, output, 1, sticky; set on the first decode error.

Behaviour:
- Reset: slave_sel_d=0, burst_sel=0, state=IDLE, err_count=0, err_addr=0, err_valid=0.
  - Outputs after reset: src_hready_resp=1, src_hresp=0, src_hexokay=0.
- Address decode, combinational:
  - IDLE: sel_a=0, no error.
  - NONSEQ: hit vector computed from ADDR_MAP/ADDR_MASK. sel_a = hit & CONN_MASK. err_a = (popcount(hit) != 1) | ~|(hit & CONN_MASK).
  - Any err_a forces sel_a=0.
  - SEQ/BUSY: sel_a = burst_sel; err_a = burst_err. The address is not re-decoded.
- Burst state registers update when src_hready=1:
  - On NONSEQ: burst_sel <= sel_a, burst_err <= err_a.
  - On IDLE: both cleared.
- Address passthrough: all fields are broadcast to every port. dst_htrans[i] = sel_a[i] ? src_htrans : IDLE.
- dst_hready = {N_PORTS{src_hready}}; dst_hwdata is broadcast.
- Data-phase registers when src_hready=1: slave_sel_d <= sel_a, and state advances.
- State machine:
  - IDLE → DATA when sel_a != 0.
  - IDLE → ERR1 when err_a.
  - DATA: outputs are muxed from the selected port. Next state is decided by the new address phase when src_hready=1.
  - ERR1: src_hready_resp=0, src_hresp=1. Always → ERR2.
  - ERR2: src_hready_resp=1, src_hresp=1. Next state from the current address phase: a SEQ after an erroring NONSEQ errors again (burst_err).
- Data-phase outputs:
  - src_hrdata is the one-hot mux of dst_hrdata by slave_sel_d; it is 0 when none is selected.
  - In DATA, src_hready_resp and src_hresp are taken from the selected port.
  - A BUSY beat or no selection gives zero-wait OKAY.
  - src_hexokay = |(slave_sel_d & dst_hexokay); forced 0 in ERR1/ERR2.
- Timing rule: there is no combinational path from src_htrans or src_haddr to src_hready_resp or src_hresp; those outputs use only registered state.
- Error capture happens on entry to ERR1:
  - err_addr <= src_haddr of the erroring address phase.
  - err_valid <= 1.
  - err_count increments and saturates at all-ones.
- Slave ERROR (dst_hresp) is passed through unchanged and is not counted.
- A slave wait state (dst_hready_resp=0) holds slave_sel_d, burst_sel and state.
- Reset mid-transfer returns every register to its reset value immediately (asynchronous).

Test Plan:
- N_PORTS=2, port0 MAP 0x0000_0000 / MASK 0xF000_0000, port1 0x2000_0000 / 0xF000_0000.
  - NONSEQ read 0x2000_0010, port1 returns 0xCAFEF00D with 1 wait state → dst_htrans[1]=NONSEQ, dst_htrans[0]=IDLE; src_hrdata=0xCAFEF00D after the wait; slave_sel_d=2'b10.
- INCR4 starting at 0x0FFF_FFF8 → all 4 beats go to port0, including beats at 0x1000_0000+; port1 htrans stays IDLE throughout.
- NONSEQ to 0x4000_0000 → one cycle hready_resp=0/hresp=1, then one cycle 1/1; err_addr=0x4000_0000, err_count=1, err_valid=1.
- CONN_MASK=2'b01, access 0x2000_0000 → two-cycle ERROR; port1 sees no transfer.
- Overlapping maps (both ports MAP 0 / MASK 0) → decode error.
- W_ERRCNT=2, 5 errors → err_count saturates at 3.
- Assert rst_n low during ERR1 → next cycle src_hready_resp=1, src_hresp=0, err_count=0.
- dst_hexokay[0]=1 on an exclusive to port0 → src_hexokay=1 for that data phase only.

Source files
------------

// File: rtl/ahbl_splitter_burst.sv
// ahbl_splitter_burst: AHB-lite 1:N splitter with burst-sticky decode, a built-in
// error slave for bad decodes, and capture/counting of decode errors.
module ahbl_splitter_burst #(
    parameter int                        N_PORTS   = 2,
    parameter int                        W_ADDR    = 32,
    parameter int                        W_DATA    = 32,
    parameter int                        W_MASTER  = 8,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0,
    parameter logic [N_PORTS-1:0]        CONN_MASK = '1,
    parameter int                        W_ERRCNT  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          src_hready,
    output logic                          src_hready_resp,
    output logic                          src_hresp,
    input  logic [W_ADDR-1:0]             src_haddr,
    input  logic                          src_hwrite,
    input  logic [1:0]                    src_htrans,
    input  logic [2:0]                    src_hsize,
    input  logic [2:0]                    src_hburst,
    input  logic [3:0]                    src_hprot,
    input  logic                          src_hmastlock,
    input  logic                          src_hexcl,
    input  logic [W_MASTER-1:0]           src_hmaster,
    input  logic [W_DATA-1:0]             src_hwdata,
    output logic [W_DATA-1:0]             src_hrdata,
    output logic                          src_hexokay,
    output logic [N_PORTS-1:0]            dst_hready,
    input  logic [N_PORTS-1:0]            dst_hready_resp,
    input  logic [N_PORTS-1:0]            dst_hresp,
    input  logic [N_PORTS-1:0]            dst_hexokay,
    output logic [N_PORTS*W_ADDR-1:0]     dst_haddr,
    output logic [N_PORTS-1:0]            dst_hwrite,
    output logic [N_PORTS*2-1:0]          dst_htrans,
    output logic [N_PORTS*3-1:0]          dst_hsize,
    output logic [N_PORTS*3-1:0]          dst_hburst,
    output logic [N_PORTS*4-1:0]          dst_hprot,
    output logic [N_PORTS-1:0]            dst_hmastlock,
    output logic [N_PORTS-1:0]            dst_hexcl,
    output logic [N_PORTS*W_MASTER-1:0]   dst_hmaster,
    output logic [N_PORTS*W_DATA-1:0]     dst_hwdata,
    input  logic [N_PORTS*W_DATA-1:0]     dst_hrdata,
    output logic [N_PORTS-1:0]            slave_sel_d,
    output logic [W_ERRCNT-1:0]           err_count,
    output logic [W_ADDR-1:0]             err_addr,
    output logic                          err_valid
);
    localparam int W_CNT = $clog2(N_PORTS + 1);
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    state_t             state;
    logic [N_PORTS-1:0] hit, sel_a, burst_sel;
    logic [W_CNT-1:0]   n_hit;
    logic               burst_err, err_a, nseq_err, busy_d;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign hit[i] = (src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR];
        assign dst_htrans[2*i +: 2] = sel_a[i] ? src_htrans : T_IDLE;
    end

    always_comb begin
        n_hit = '0;
        for (int i = 0; i < N_PORTS; i++)
            n_hit = n_hit + W_CNT'(hit[i]);
    end

    // SEQ/BUSY beats reuse the NONSEQ decision so a burst never straddles ports
    assign nseq_err = (n_hit != W_CNT'(1)) || !(|(hit & CONN_MASK));
    assign err_a = src_htrans == T_NSEQ ? nseq_err : src_htrans == T_IDLE ? 1'b0 : burst_err;
    assign sel_a = src_htrans == T_NSEQ ? (nseq_err ? '0 : hit & CONN_MASK)
                 : src_htrans == T_IDLE ? '0 : burst_sel;

    assign dst_hready    = {N_PORTS{src_hready}};
    assign dst_haddr     = {N_PORTS{src_haddr}};
    assign dst_hwrite    = {N_PORTS{src_hwrite}};
    assign dst_hsize     = {N_PORTS{src_hsize}};
    assign dst_hburst    = {N_PORTS{src_hburst}};
    assign dst_hprot     = {N_PORTS{src_hprot}};
    assign dst_hmastlock = {N_PORTS{src_hmastlock}};
    assign dst_hexcl     = {N_PORTS{src_hexcl}};
    assign dst_hmaster   = {N_PORTS{src_hmaster}};
    assign dst_hwdata    = {N_PORTS{src_hwdata}};

    always_comb begin
        src_hrdata = '0;
        for (int i = 0; i < N_PORTS; i++)
            src_hrdata = src_hrdata | ({W_DATA{slave_sel_d[i]}} & dst_hrdata[i*W_DATA +: W_DATA]);
    end

    // Responses depend only on registered state, never on the current address phase
    assign src_hready_resp = state == ERR1 ? 1'b0
                           : state == DATA && !busy_d ? |(slave_sel_d & dst_hready_resp) : 1'b1;
    assign src_hresp = state == ERR1 || state == ERR2 ? 1'b1
                     : state == DATA && !busy_d ? |(slave_sel_d & dst_hresp) : 1'b0;
    assign src_hexokay = state == DATA && |(slave_sel_d & dst_hexokay);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slave_sel_d <= '0;
            burst_sel   <= '0;
            burst_err   <= 1'b0;
            busy_d      <= 1'b0;
            err_count   <= '0;
            err_addr    <= '0;
            err_valid   <= 1'b0;
        end else if (state == ERR1) begin
            state <= ERR2;
        end else if (src_hready) begin
            state       <= err_a ? ERR1 : |sel_a ? DATA : IDLE;
            slave_sel_d <= sel_a;
            busy_d      <= src_htrans == T_BUSY;
            if (src_htrans == T_NSEQ) begin
                burst_sel <= sel_a;
                burst_err <= err_a;
            end else if (src_htrans == T_IDLE) begin
                burst_sel <= '0;
                burst_err <= 1'b0;
            end
            if (err_a) begin
                err_addr  <= src_haddr;
                err_valid <= 1'b1;
                err_count <= err_count + W_ERRCNT'(~&err_count);
            end
        end
    end
endmodule

// File: tb/tb_ahbl_splitter_burst.sv
// tb_ahbl_splitter_burst: three splitter configs (normal, port1 disconnected with a
// 2-bit error counter, fully overlapping maps) checked against a transaction-level model.
module tb_ahbl_splitter_burst;
    localparam int NI = 3;
    localparam logic [63:0] MAP_STD  = {32'h2000_0000, 32'h0000_0000};
    localparam logic [63:0] MASK_STD = {32'hF000_0000, 32'hF000_0000};

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] haddr, hwdata;
    logic        hwrite, hmastlock, hexcl;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [7:0]  hmaster;
    logic [1:0]  d_rdy, d_resp, d_exok;
    logic [63:0] d_rdata;

    logic        hr[NI], hrs[NI], exok[NI], ev[NI];
    logic [31:0] rd[NI], ea[NI];
    logic [15:0] ec[NI];
    logic [1:0]  ssd[NI], drdy[NI];
    logic [3:0]  dtr[NI];
    logic [63:0] dad[NI], dwd[NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WE = g == 1 ? 2 : 16;
        logic [WE-1:0] ecl;
        logic [1:0]    dw, dml, dex;
        logic [5:0]    dsz, dbu;
        logic [7:0]    dpr;
        logic [15:0]   dms;
        ahbl_splitter_burst #(
            .N_PORTS(2), .W_ADDR(32), .W_DATA(32), .W_MASTER(8),
            .ADDR_MAP(g == 2 ? 64'h0 : MAP_STD), .ADDR_MASK(g == 2 ? 64'h0 : MASK_STD),
            .CONN_MASK(g == 1 ? 2'b01 : 2'b11), .W_ERRCNT(WE)
        ) dut (
            .clk(clk), .rst_n(rst_n), .src_hready(hr[g]), .src_hready_resp(hr[g]), .src_hresp(hrs[g]),
            .src_haddr(haddr), .src_hwrite(hwrite), .src_htrans(htrans), .src_hsize(hsize),
            .src_hburst(hburst), .src_hprot(hprot), .src_hmastlock(hmastlock), .src_hexcl(hexcl),
            .src_hmaster(hmaster), .src_hwdata(hwdata), .src_hrdata(rd[g]), .src_hexokay(exok[g]),
            .dst_hready(drdy[g]), .dst_hready_resp(d_rdy), .dst_hresp(d_resp), .dst_hexokay(d_exok),
            .dst_haddr(dad[g]), .dst_hwrite(dw), .dst_htrans(dtr[g]), .dst_hsize(dsz), .dst_hburst(dbu),
            .dst_hprot(dpr), .dst_hmastlock(dml), .dst_hexcl(dex), .dst_hmaster(dms), .dst_hwdata(dwd[g]),
            .dst_hrdata(d_rdata), .slave_sel_d(ssd[g]), .err_count(ecl), .err_addr(ea[g]), .err_valid(ev[g])
        );
        assign ec[g] = 16'(ecl);
    end

    int checks = 0, errors = 0;

    task automatic chk(string n, int k, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", n, k, $time, a, e);
        end
    endtask

    // Model: dp = target of the outstanding data phase (-2 none, -1 error slave, else port),
    // bsel = target every SEQ/BUSY beat of the current burst goes to.
    int          dp[NI], ecyc[NI], bsel[NI], ecnt[NI];
    bit          dbusy[NI], evalid[NI];
    logic [31:0] eaddr[NI];

    function automatic int decode(int k, logic [31:0] a);
        int n, p;
        logic [31:0] base, msk;
        n = 0;
        p = -1;
        for (int i = 0; i < 2; i++) begin
            base = k == 2 ? 32'h0 : (i == 1 ? 32'h2000_0000 : 32'h0);
            msk  = k == 2 ? 32'h0 : 32'hF000_0000;
            if ((a & msk) == base) begin
                n++;
                p = i;
            end
        end
        if (n != 1 || (k == 1 && p == 1)) return -1;
        return p;
    endfunction

    function automatic int aphase(int k);
        if (htrans == 2'b00) return -2;
        if (htrans == 2'b10) return decode(k, haddr);
        return bsel[k];
    endfunction

    function automatic logic exp_hr(int k);
        if (dp[k] == -1) return ecyc[k] == 2;
        if (dp[k] >= 0 && !dbusy[k]) return d_rdy[dp[k]];
        return 1'b1;
    endfunction

    function automatic logic exp_hrs(int k);
        if (dp[k] == -1) return 1'b1;
        if (dp[k] >= 0 && !dbusy[k]) return d_resp[dp[k]];
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_rd(int k);
        return dp[k] >= 0 ? d_rdata[dp[k]*32 +: 32] : 32'h0;
    endfunction

    function automatic logic exp_ex(int k);
        return dp[k] >= 0 && d_exok[dp[k]];
    endfunction

    function automatic logic [1:0] exp_ssd(int k);
        return dp[k] >= 0 ? 2'(1 << dp[k]) : 2'b00;
    endfunction

    function automatic logic [3:0] exp_dtr(int k);
        logic [3:0] r;
        int ap;
        r = '0;
        ap = aphase(k);
        if (ap >= 0) r[ap*2 +: 2] = htrans;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                dp[k] <= -2; ecyc[k] <= 1; bsel[k] <= -2; dbusy[k] <= 1'b0;
                ecnt[k] <= 0; eaddr[k] <= '0; evalid[k] <= 1'b0;
            end else if (dp[k] == -1 && ecyc[k] == 1) begin
                ecyc[k] <= 2;
            end else if (exp_hr(k)) begin
                dp[k] <= aphase(k);
                ecyc[k] <= 1;
                dbusy[k] <= htrans == 2'b01;
                if (htrans == 2'b10) bsel[k] <= aphase(k);
                else if (htrans == 2'b00) bsel[k] <= -2;
                if (aphase(k) == -1) begin
                    eaddr[k] <= haddr;
                    evalid[k] <= 1'b1;
                    if (ecnt[k] < (k == 1 ? 3 : 65535)) ecnt[k] <= ecnt[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk("hready_resp", k, hr[k], exp_hr(k));
            chk("hresp", k, hrs[k], exp_hrs(k));
            chk("hrdata", k, rd[k], exp_rd(k));
            chk("hexokay", k, exok[k], exp_ex(k));
            chk("slave_sel_d", k, ssd[k], exp_ssd(k));
            chk("err_count", k, ec[k], 64'(ecnt[k]));
            chk("err_addr", k, ea[k], eaddr[k]);
            chk("err_valid", k, ev[k], evalid[k]);
            chk("dst_htrans", k, dtr[k], exp_dtr(k));
            chk("dst_haddr", k, dad[k], {haddr, haddr});
            chk("dst_hwdata", k, dwd[k], {hwdata, hwdata});
            chk("dst_hready", k, drdy[k], {2{exp_hr(k)}});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] picks[6] = '{32'h0000_0100, 32'h2000_0010, 32'h4000_0000,
                              32'h0FFF_FFF8, 32'h1000_0000, 32'h2FFF_FFFC};
    int          beats = 0, idx;
    logic        acc;

    initial begin
        htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hprot = 4'h3;
        hmastlock = 1'b0; hexcl = 1'b0; hmaster = 8'h5A; hwdata = '0;
        d_rdy = 2'b11; d_resp = 2'b00; d_exok = 2'b00; d_rdata = {32'hCAFE_F00D, 32'h1111_1111};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_hready", 0, hr[0], 1); chk("rst_hresp", 0, hrs[0], 0);
        chk("rst_errcnt", 0, ec[0], 0); chk("rst_errvalid", 0, ev[0], 0); chk("rst_sel", 0, ssd[0], 0);
        // read of port1 with one wait state; B sees a disconnected port, C an overlap
        step(); htrans = 2'b10; haddr = 32'h2000_0010;
        @(negedge clk);
        chk("rd_htrans", 0, dtr[0], 4'b1000); chk("rd_htrans", 1, dtr[1], 4'b0000); chk("rd_htrans", 2, dtr[2], 4'b0000);
        step(); htrans = 2'b00; d_rdy = 2'b01;
        @(negedge clk);
        chk("wait_hready", 0, hr[0], 0); chk("err1_hready", 1, hr[1], 0);
        chk("err1_hresp", 1, hrs[1], 1); chk("err1_hresp", 2, hrs[2], 1);
        step(); d_rdy = 2'b11;
        @(negedge clk);
        chk("rd_data", 0, rd[0], 32'hCAFE_F00D); chk("rd_sel", 0, ssd[0], 2'b10); chk("rd_hready", 0, hr[0], 1);
        chk("err2_hready", 1, hr[1], 1); chk("err2_hresp", 1, hrs[1], 1); chk("err_addr", 1, ea[1], 32'h2000_0010);
        repeat (3) step();
        // unmapped access
        step(); htrans = 2'b10; haddr = 32'h4000_0000;
        step(); htrans = 2'b00;
        @(negedge clk);
        chk("err1_hready", 0, hr[0], 0); chk("err1_hresp", 0, hrs[0], 1);
        @(negedge clk);
        chk("err2_hready", 0, hr[0], 1); chk("err2_hresp", 0, hrs[0], 1);
        chk("err_addr", 0, ea[0], 32'h4000_0000); chk("err_count", 0, ec[0], 1); chk("err_valid", 0, ev[0], 1);
        repeat (2) step();
        // INCR4 crossing into the unmapped 0x1xxx_xxxx region stays on port0
        step(); htrans = 2'b10; haddr = 32'h0FFF_FFF8; hburst = 3'd3;
        @(negedge clk);
        chk("burst_htrans", 0, dtr[0], 4'b0010);
        for (int i = 0; i < 3; i++) begin
            step(); htrans = 2'b11; haddr += 4;
            @(negedge clk);
            chk("burst_htrans", 0, dtr[0], 4'b0011);
        end
        step(); htrans = 2'b00; hburst = 3'd0;
        // exclusive to port0
        d_exok = 2'b01; hexcl = 1'b1;
        step(); htrans = 2'b10; haddr = 32'h0000_0100;
        step(); htrans = 2'b00; hexcl = 1'b0;
        @(negedge clk);
        chk("exokay", 0, exok[0], 1);
        step();
        @(negedge clk);
        chk("exokay_end", 0, exok[0], 0);
        d_exok = 2'b00;
        // randomized traffic; the master follows config A's HREADY
        repeat (3000) begin
            @(negedge clk);
            acc = hr[0];
            step();
            d_rdy = {2{1'b1}} & {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
            d_resp = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
            d_exok = 2'($urandom);
            d_rdata = {$urandom, $urandom};
            hwdata = $urandom;
            if (acc) begin
                if (beats > 0 && $urandom_range(0, 5) == 0) htrans = 2'b01;
                else if (beats > 0) begin
                    htrans = 2'b11; haddr += 4; beats--;
                end else if ($urandom_range(0, 3) == 0) htrans = 2'b00;
                else begin
                    idx = $urandom_range(0, 6);
                    htrans = 2'b10;
                    haddr = idx == 6 ? ($urandom & 32'hFFFF_FFFC) : picks[idx];
                    beats = $urandom_range(0, 3);
                    hwrite = 1'($urandom);
                    hexcl = 1'($urandom);
                end
            end
        end
        // quiesce, then reset in the middle of an error response
        step(); htrans = 2'b00; d_rdy = 2'b11; d_resp = 2'b00; beats = 0;
        repeat (4) step();
        step(); htrans = 2'b10; haddr = 32'h4000_0000;
        step(); htrans = 2'b00;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_hready", 0, hr[0], 1); chk("rst_mid_hresp", 0, hrs[0], 0); chk("rst_mid_count", 0, ec[0], 0);
        step(); rst_n = 1'b1;
        // five decode errors: 2-bit counter saturates
        repeat (5) begin
            step(); htrans = 2'b10; haddr = 32'h4000_0000;
            step(); htrans = 2'b00;
            repeat (3) step();
        end
        @(negedge clk);
        chk("sat_count", 1, ec[1], 3); chk("count5", 0, ec[0], 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
